// File: rtl/video_sig_pkg.sv
// video_sig_pkg: shared types and helpers for the video frame-signature unit.
// Holds the capture state enum, the streaming hash step and common widths.
package video_sig_pkg;

  // Width of the per-frame hashed-pixel counter.
  localparam int PIX_CNT_W = 20;
  // Width of the raster x/y position counters.
  localparam int RASTER_W  = 16;
  // Widest hash the step function supports; narrower hashes truncate its result.
  localparam int HASH_MAX_W = 64;

  typedef enum logic {
    WAIT_VS = 1'b0,
    CAPTURE = 1'b1
  } sig_state_e;

  // One hash step: rgb + (hash << 6) + (hash << 16) - hash, i.e. hash*65599 + rgb.
  function automatic logic [HASH_MAX_W-1:0] sig_hash_step(
    input logic [HASH_MAX_W-1:0] rgb,
    input logic [HASH_MAX_W-1:0] hash
  );
    return rgb + (hash << 3'd6) + (hash << 5'd16) - hash;
  endfunction

endpackage

// File: rtl/video_raster_cnt.sv
// video_raster_cnt: sync edge detection, raster x/y tracking and the
// active-window / decimation decode for the frame-signature unit.
module video_raster_cnt
  import video_sig_pkg::*;
#(
  parameter int H_ACTIVE = 700,
  parameter int V_ACTIVE = 500,
  parameter int H_START  = 5,
  parameter int V_START  = 5,
  parameter int DECIM    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic hsync,
  input  logic vsync,
  output logic sample_en,
  output logic frame_end
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [RASTER_W-1:0] X_LO    = RASTER_W'(H_START);
  localparam logic [RASTER_W-1:0] X_HI    = RASTER_W'(H_START + DECIM * H_ACTIVE);
  localparam logic [RASTER_W-1:0] Y_LO    = RASTER_W'(V_START);
  localparam logic [RASTER_W-1:0] Y_HI    = RASTER_W'(V_START + V_ACTIVE);
  localparam logic [PH_W-1:0]     PH_LAST = PH_W'(DECIM - 1);

  logic                last_hsync;
  logic                last_vsync;
  logic [RASTER_W-1:0] x;
  logic [RASTER_W-1:0] y;
  logic [PH_W-1:0]     ph;
  logic                line_start;
  logic                active;
  logic                in_x;
  logic                in_y;

  assign line_start = hsync & ~last_hsync;
  // A frame ends on the first clock with vsync high and hsync low; when both
  // syncs overlap, the line increment happens first and the frame ends once
  // hsync drops.
  assign frame_end  = vsync & ~hsync & ~(last_vsync & ~last_hsync);
  assign active     = ~hsync & ~vsync;
  assign in_x       = (x >= X_LO) && (x < X_HI);
  assign in_y       = (y >= Y_LO) && (y < Y_HI);
  // ph tracks (x - H_START) % DECIM incrementally, avoiding a divider.
  assign sample_en  = active & in_x & in_y & (ph == '0);

  // Track sync history, horizontal position, decimation phase and line index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_hsync <= 1'b0;
      last_vsync <= 1'b0;
      x          <= '0;
      y          <= '0;
      ph         <= '0;
    end else begin
      last_hsync <= hsync;
      last_vsync <= vsync;
      if (hsync) begin
        if (line_start) begin
          x  <= '0;
          ph <= '0;
          // y saturates so an endless run of lines never re-enters the window.
          if (y != '1) y <= y + 1'b1;
        end
      end else if (vsync) begin
        if (frame_end) begin
          x  <= '0;
          y  <= '0;
          ph <= '0;
        end
      end else begin
        if (x != '1) x <= x + 1'b1;
        if (x < X_LO)            ph <= '0;
        else if (ph == PH_LAST)  ph <= '0;
        else                     ph <= ph + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_frame_sig.sv
// video_frame_sig: passive observer that folds the sampled active window of
// each video frame into a streaming hash and reports one signature per frame.
// Optional golden comparator: define SIG_GOLDEN_CMP_EN to add exp_hash/match/
// mismatch_sticky.
module video_frame_sig
  import video_sig_pkg::*;
#(
  parameter int RGB_W    = 3,
  parameter int H_ACTIVE = 700,
  parameter int V_ACTIVE = 500,
  parameter int H_START  = 5,
  parameter int V_START  = 5,
  parameter int DECIM    = 2,
  parameter int HASH_W   = 64,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [RGB_W-1:0]     rgb,
  output logic                 frame_done,
  output logic [HASH_W-1:0]    frame_hash,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [PIX_CNT_W-1:0] pix_cnt,
  output logic                 err_short
`ifdef SIG_GOLDEN_CMP_EN
  ,
  input  logic [HASH_W-1:0]    exp_hash,
  output logic                 match,
  output logic                 mismatch_sticky
`endif
);

  localparam logic [PIX_CNT_W-1:0] FULL_CNT = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);

  sig_state_e           state;
  logic [HASH_W-1:0]    hash;
  logic [HASH_W-1:0]    hash_next;
  logic [PIX_CNT_W-1:0] cnt;
  logic                 sample_en;
  logic                 frame_end;

  video_raster_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_START  (H_START),
    .V_START  (V_START),
    .DECIM    (DECIM)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .hsync     (hsync),
    .vsync     (vsync),
    .sample_en (sample_en),
    .frame_end (frame_end)
  );

  assign hash_next = HASH_W'(sig_hash_step(HASH_MAX_W'(rgb), HASH_MAX_W'(hash)));

  // Capture state machine: arm on the first frame boundary, then hash samples
  // and publish the signature at every following boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_VS;
      hash       <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
      frame_hash <= '0;
      frame_cnt  <= '0;
      pix_cnt    <= '0;
      err_short  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (frame_end) begin
            state <= CAPTURE;
            hash  <= '0;
            cnt   <= '0;
          end
        end
        CAPTURE: begin
          if (frame_end) begin
            frame_done <= 1'b1;
            frame_hash <= hash;
            pix_cnt    <= cnt;
            err_short  <= (cnt != FULL_CNT);
            frame_cnt  <= frame_cnt + 1'b1;
            hash       <= '0;
            cnt        <= '0;
          end else if (sample_en) begin
            hash <= hash_next;
            if (cnt != '1) cnt <= cnt + 1'b1;
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

`ifdef SIG_GOLDEN_CMP_EN
  // Compare each completed signature with the expected one; remember any miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match           <= 1'b0;
      mismatch_sticky <= 1'b0;
    end else if ((state == CAPTURE) && frame_end) begin
      match <= (hash == exp_hash);
      if (hash != exp_hash) mismatch_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_video_frame_sig.sv
// Bench for video_frame_sig: two instances (plain geometry and a decimated
// one) share the same sync/pixel stimulus and are compared against a
// frame-level reference model plus a table of hand-computed signatures.
module tb_video_frame_sig;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic        fd_a, es_a, fd_b, es_b;
  logic [63:0] fh_a, fh_b;
  logic [15:0] fc_a, fc_b;
  logic [19:0] pc_a, pc_b;
`ifdef SIG_GOLDEN_CMP_EN
  logic [63:0] exp_hash;
  logic        match_a, sticky_a, match_b, sticky_b;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  video_frame_sig #(.RGB_W(3), .H_ACTIVE(2), .V_ACTIVE(1), .H_START(0), .V_START(1),
                    .DECIM(1), .HASH_W(64), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_done(fd_a), .frame_hash(fh_a), .frame_cnt(fc_a), .pix_cnt(pc_a), .err_short(es_a)
`ifdef SIG_GOLDEN_CMP_EN
    , .exp_hash(exp_hash), .match(match_a), .mismatch_sticky(sticky_a)
`endif
  );

  video_frame_sig #(.RGB_W(3), .H_ACTIVE(4), .V_ACTIVE(3), .H_START(2), .V_START(1),
                    .DECIM(3), .HASH_W(64), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_done(fd_b), .frame_hash(fh_b), .frame_cnt(fc_b), .pix_cnt(pc_b), .err_short(es_b)
`ifdef SIG_GOLDEN_CMP_EN
    , .exp_hash(64'd0), .match(match_b), .mismatch_sticky(sticky_b)
`endif
  );

  // Reference model: geometry per instance, running hash/count per frame.
  int          m_ha [2] = '{2, 4};
  int          m_va [2] = '{1, 3};
  int          m_hs [2] = '{0, 2};
  int          m_vs [2] = '{1, 1};
  int          m_dc [2] = '{1, 3};
  logic [63:0] m_hash [2];
  int          m_cnt [2];
  int          m_fcnt [2];
  bit          capturing = 1'b0;

  typedef struct {
    logic [63:0] h;
    int          pix;
    bit          err;
    int          fcnt;
    int          at;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  typedef struct {
    int          n;
    int          len;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic [63:0] h;
    int          pix;
    bit          err;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [2:0] rnd();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic bit in_win(input int d, input int y, input int x);
    return (x >= m_hs[d]) && (x < m_hs[d] + m_dc[d] * m_ha[d]) &&
           ((x - m_hs[d]) % m_dc[d] == 0) &&
           (y >= m_vs[d]) && (y < m_vs[d] + m_va[d]);
  endfunction

  task automatic model_pix(input int y, input int x, input logic [2:0] r);
    for (int d = 0; d < 2; d++) begin
      if (in_win(d, y, x)) begin
        m_hash[d] = m_hash[d] * 64'd65599 + 64'(r);
        m_cnt[d]  = m_cnt[d] + 1;
      end
    end
  endtask

  task automatic model_reset();
    capturing = 1'b0;
    q_a.delete();
    q_b.delete();
    for (int d = 0; d < 2; d++) begin
      m_hash[d] = 64'd0;
      m_cnt[d]  = 0;
      m_fcnt[d] = 0;
    end
  endtask

  task automatic check_dut(input int d, input logic fd, input logic [63:0] fh,
                           input logic [15:0] fc, input logic [19:0] pc, input logic es);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
    if (have) begin
      if (d == 0) e = q_a[0];
      else        e = q_b[0];
    end
    if (fd === 1'b1 || (have && cyc >= e.at)) begin
      if (!have) begin
        chk($sformatf("dut%0d_unexpected_done", d), 64'(fd), 64'd0);
      end else begin
        if (d == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
        chk($sformatf("dut%0d_done", d), 64'(fd), 64'd1);
        chk($sformatf("dut%0d_done_cycle", d), 64'(cyc), 64'(e.at));
        chk($sformatf("dut%0d_hash", d), fh, e.h);
        chk($sformatf("dut%0d_pix_cnt", d), 64'(pc), 64'(e.pix));
        chk($sformatf("dut%0d_err_short", d), 64'(es), 64'(e.err));
        chk($sformatf("dut%0d_frame_cnt", d), 64'(fc), 64'(e.fcnt));
      end
    end
  endtask

  task automatic tick(input logic h, input logic v, input logic [2:0] r);
    hsync = h;
    vsync = v;
    rgb   = r;
    @(posedge clk);
    cyc++;
    #1;
    check_dut(0, fd_a, fh_a, fc_a, pc_a, es_a);
    check_dut(1, fd_b, fh_b, fc_b, pc_b, es_b);
  endtask

  // Called just before the clock at which the frame boundary is sampled.
  task automatic close_frame();
    exp_t e;
    if (capturing) begin
      for (int d = 0; d < 2; d++) begin
        m_fcnt[d] = (m_fcnt[d] + 1) % 65536;
        e.h    = m_hash[d];
        e.pix  = m_cnt[d];
        e.err  = (m_cnt[d] != m_ha[d] * m_va[d]);
        e.fcnt = m_fcnt[d];
        e.at   = cyc + 1;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end
    end
    capturing = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_hash[d] = 64'd0;
      m_cnt[d]  = 0;
    end
  endtask

  task automatic vs_pulse();
    close_frame();
    tick(1'b0, 1'b1, rnd());
    tick(1'b0, 1'b1, rnd());
  endtask

  // hsync and vsync overlap; the frame closes on the clock hsync drops.
  task automatic hv_close();
    tick(1'b1, 1'b1, rnd());
    tick(1'b1, 1'b1, rnd());
    close_frame();
    tick(1'b0, 1'b1, rnd());
    tick(1'b0, 1'b1, rnd());
  endtask

  task automatic body(input int n, input int len, input int gap, input bit fixed,
                      input logic [2:0] r0, input logic [2:0] r1);
    logic [2:0] r;
    for (int j = 0; j < gap; j++) begin
      r = rnd();
      if (capturing) model_pix(0, j, r);
      tick(1'b0, 1'b0, r);
    end
    for (int k = 1; k <= n; k++) begin
      tick(1'b1, 1'b0, rnd());
      tick(1'b1, 1'b0, rnd());
      for (int j = 0; j < len; j++) begin
        if (fixed) r = (j == 0) ? r0 : r1;
        else       r = rnd();
        if (capturing) model_pix(k, j, r);
        tick(1'b0, 1'b0, r);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done_a"},  64'(fd_a), 64'd0);
    chk({tag, "_hash_a"},  fh_a, 64'd0);
    chk({tag, "_fcnt_a"},  64'(fc_a), 64'd0);
    chk({tag, "_pix_a"},   64'(pc_a), 64'd0);
    chk({tag, "_err_a"},   64'(es_a), 64'd0);
    chk({tag, "_hash_b"},  fh_b, 64'd0);
    chk({tag, "_fcnt_b"},  64'(fc_b), 64'd0);
`ifdef SIG_GOLDEN_CMP_EN
    chk({tag, "_match_a"},  64'(match_a), 64'd0);
    chk({tag, "_sticky_a"}, 64'(sticky_a), 64'd0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    rgb   = 3'd0;
`ifdef SIG_GOLDEN_CMP_EN
    exp_hash = 64'd65601;
`endif
    // {lines, line length, rgb first, rgb rest, hash, pix_cnt, err_short} for dut_a
    tbl[0] = '{1, 2, 3'd1, 3'd2, 64'd65601,  2, 1'b0};
    tbl[1] = '{1, 2, 3'd0, 3'd0, 64'd0,      2, 1'b0};
    tbl[2] = '{1, 2, 3'd7, 3'd7, 64'd459200, 2, 1'b0};
    tbl[3] = '{1, 1, 3'd5, 3'd0, 64'd5,      1, 1'b1};
    tbl[4] = '{0, 0, 3'd0, 3'd0, 64'd0,      0, 1'b1};
    tbl[5] = '{2, 4, 3'd3, 3'd1, 64'd196798, 2, 1'b0};
    tbl[6] = '{1, 3, 3'd2, 3'd6, 64'd131204, 2, 1'b0};
    model_reset();

    #1;
    chk_zero("reset");
    tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 3'd0);
    reset = 1'b0;

    // Activity before the first vsync is ignored.
    body(2, 5, 1, 1'b0, 3'd0, 3'd0);
    chk("pre_vs_frame_cnt_a", 64'(fc_a), 64'd0);
    chk("pre_vs_frame_cnt_b", 64'(fc_b), 64'd0);

    // Arm, then the fixed-signature table.
    vs_pulse();
    for (int i = 0; i < 7; i++) begin
      body(tbl[i].n, tbl[i].len, 1, 1'b1, tbl[i].r0, tbl[i].r1);
      vs_pulse();
      chk($sformatf("tbl%0d_hash", i), fh_a, tbl[i].h);
      chk($sformatf("tbl%0d_pix", i), 64'(pc_a), 64'(tbl[i].pix));
      chk($sformatf("tbl%0d_err", i), 64'(es_a), 64'(tbl[i].err));
    end
    chk("tbl_frame_cnt_a", 64'(fc_a), 64'd7);

    // Random geometry and pixels against the model.
    for (int i = 0; i < 14; i++) begin
      body($urandom_range(0, 5), $urandom_range(0, 16), $urandom_range(1, 3), 1'b0, 3'd0, 3'd0);
      if (i % 3 == 2) hv_close();
      else            vs_pulse();
    end

    // Overlapping syncs closing a known frame.
    body(1, 2, 1, 1'b1, 3'd1, 3'd2);
    hv_close();
    chk("hv_close_hash", fh_a, 64'd65601);

    // Asynchronous reset mid-frame, away from any clock edge.
    body(1, 6, 1, 1'b0, 3'd0, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    model_reset();
    tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    body(2, 6, 1, 1'b0, 3'd0, 3'd0);
    chk("post_reset_no_frame", 64'(fc_a), 64'd0);
    vs_pulse();
    body(1, 2, 1, 1'b1, 3'd1, 3'd2);
    vs_pulse();
    chk("post_reset_hash", fh_a, 64'd65601);
    chk("post_reset_fcnt", 64'(fc_a), 64'd1);

`ifdef SIG_GOLDEN_CMP_EN
    chk("golden_match_1", 64'(match_a), 64'd1);
    chk("golden_sticky_1", 64'(sticky_a), 64'd0);
    exp_hash = 64'd0;
    body(1, 2, 1, 1'b1, 3'd1, 3'd2);
    vs_pulse();
    chk("golden_match_2", 64'(match_a), 64'd0);
    chk("golden_sticky_2", 64'(sticky_a), 64'd1);
    exp_hash = 64'd65601;
    body(1, 2, 1, 1'b1, 3'd1, 3'd2);
    vs_pulse();
    chk("golden_match_3", 64'(match_a), 64'd1);
    chk("golden_sticky_3", 64'(sticky_a), 64'd1);
`endif

    tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 3'd0);
    chk("pending_done", 64'(q_a.size() + q_b.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
